code_patch_loader: RTL and testbench

CODE_PATCH_LOADER -- requirements
Module: code_patch_loader

---
 rtl/code_patch_pkg.sv | 21 ++
 rtl/code_patch_shreg.sv | 63 ++++++
 rtl/code_patch_loader.sv | 123 ++++++++++++
 tb/tb_code_patch_loader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/code_patch_pkg.sv
// Shared types and sizing for the code patch loader.
package code_patch_pkg;

  localparam int ENTRY_W     = 22;
  localparam int ADDR_W      = 13;
  localparam int DATA_W      = ENTRY_W - ADDR_W;
  localparam int NUM_ENTRIES = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } patch_entry_t;

endpackage

// File: rtl/code_patch_shreg.sv
// Serial-to-parallel shifter, MSB first, with bit counter and full flag.
// Once full, the register freezes until cleared so the assembled word can be
// presented straight from it.
module code_patch_shreg #(
  parameter int ENTRY_W = code_patch_pkg::ENTRY_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               shift_en_i,
  input  logic               bit_i,
  output logic [ENTRY_W-1:0] data_o,
  output logic               last_o,
  output logic               full_o
);

  localparam int CNT_W = $clog2(ENTRY_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ENTRY_W - 1);

  logic [ENTRY_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               full_q, full_d;
  logic               shift_ok;

  assign shift_ok = shift_en_i & ~full_q & ~clr_i;
  assign last_o   = shift_ok & (cnt_q == CNT_LAST);
  assign data_o   = data_q;
  assign full_o   = full_q;

  // Next-state: clear wins, otherwise shift one bit and count it.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    full_d = full_q;
    if (clr_i) begin
      data_d = '0;
      cnt_d  = '0;
      full_d = 1'b0;
    end else if (shift_ok) begin
      data_d = {data_q[ENTRY_W-2:0], bit_i};
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        full_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/code_patch_loader.sv
// Loads NUM_ENTRIES serial patch entries and hands each to the patch core
// through a valid/ready handshake.
//
// state      | meaning
// IDLE       | waiting for load enable; shifter held clear
// SHIFT      | collecting serial bits of entry idx
// PRESENT    | entry idx on entry_o, waiting for ready
// DONE       | all entries accepted; held until enable drops
module code_patch_loader #(
  parameter int ENTRY_W     = code_patch_pkg::ENTRY_W,
  parameter int ADDR_W      = code_patch_pkg::ADDR_W,
  parameter int NUM_ENTRIES = code_patch_pkg::NUM_ENTRIES
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_pat_gen_i,
  input  logic               si_data_i,
  input  logic               si_valid_i,
  input  logic               entry_ready_i,
  output logic [ENTRY_W-1:0] entry_o,
  output logic [1:0]         entry_idx_o,
  output logic               entry_valid_o,
  output logic               load_done_o,
  output logic               overrun_o
);

  import code_patch_pkg::*;

  localparam int LDR_DATA_W = ENTRY_W - ADDR_W;
  localparam logic [1:0] IDX_LAST = 2'(NUM_ENTRIES - 1);

  state_e             state_q;
  logic [1:0]         idx_q;
  logic               valid_q;
  logic               done_q;
  logic               ovr_q;

  logic               shift_en;
  logic               accept;
  logic               shreg_clr;
  logic               shreg_last;
  logic               shreg_full;
  logic [ENTRY_W-1:0] shreg_data;

  assign shift_en  = cfg_pat_gen_i & (state_q == ST_SHIFT) & si_valid_i;
  assign accept    = (state_q == ST_PRESENT) & valid_q & entry_ready_i;
  // Clearing on accept means bits dropped during PRESENT never leak into
  // the next entry; clearing in IDLE guarantees each load starts at bit 0.
  assign shreg_clr = ~cfg_pat_gen_i | (state_q == ST_IDLE) | accept;

  code_patch_shreg #(
    .ENTRY_W (ENTRY_W)
  ) u_shreg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (shreg_clr),
    .shift_en_i (shift_en),
    .bit_i      (si_data_i),
    .data_o     (shreg_data),
    .last_o     (shreg_last),
    .full_o     (shreg_full)
  );

  // The shifter freezes when full, so it doubles as the presented entry.
  assign entry_o       = {shreg_data[ENTRY_W-1 -: ADDR_W], shreg_data[LDR_DATA_W-1:0]};
  assign entry_idx_o   = idx_q;
  assign entry_valid_o = valid_q & shreg_full;
  assign load_done_o   = done_q;
  assign overrun_o     = ovr_q;

  // Load sequencing FSM with registered handshake and status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (state_q == ST_PRESENT && si_valid_i) begin
        ovr_q <= 1'b1;
      end
      if (!cfg_pat_gen_i) begin
        state_q <= ST_IDLE;
        idx_q   <= '0;
        valid_q <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_SHIFT;
            idx_q   <= '0;
          end
          ST_SHIFT: begin
            if (shreg_last) begin
              state_q <= ST_PRESENT;
              valid_q <= 1'b1;
            end
          end
          ST_PRESENT: begin
            if (accept) begin
              valid_q <= 1'b0;
              if (idx_q == IDX_LAST) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                idx_q   <= idx_q + 1'b1;
                state_q <= ST_SHIFT;
              end
            end
          end
          ST_DONE: begin
            state_q <= ST_DONE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_code_patch_loader.sv
// Self-checking bench for code_patch_loader against a small load model.
module tb_code_patch_loader;

  localparam int EW = 22;
  localparam int NE = 3;

  logic          clk = 1'b0;
  logic          rst, cfg, sd, sv, rdy;
  logic [EW-1:0] entry;
  logic [1:0]    idx;
  logic          valid, done, ovr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: entries accepted so far in this load, overrun flag.
  int exp_idx;
  bit exp_ovr;

  always #5 clk = ~clk;

  code_patch_loader dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cfg_pat_gen_i (cfg),
    .si_data_i     (sd),
    .si_valid_i    (sv),
    .entry_ready_i (rdy),
    .entry_o       (entry),
    .entry_idx_o   (idx),
    .entry_valid_o (valid),
    .load_done_o   (done),
    .overrun_o     (ovr)
  );

  // Stimulus only: enable a load from idle.
  task automatic start_load();
    @(negedge clk);
    cfg = 1'b1;
    exp_idx = 0;
  endtask

  // Stimulus only: shift a word MSB first, optionally with idle gaps, and
  // stop on the negedge one cycle after the last bit.
  task automatic send_word(input logic [EW-1:0] w, input bit gap, input bit rdy_during);
    for (int i = EW - 1; i >= 0; i--) begin
      @(negedge clk);
      rdy = rdy_during;
      sv  = 1'b1;
      sd  = w[i];
      if (gap && i > 0) begin
        @(negedge clk);
        sv = 1'b0;
        sd = 1'($urandom);
      end
    end
    @(negedge clk);
    sv = 1'b0;
  endtask

  task automatic end_load();
    @(negedge clk);
    cfg = 1'b0;
    rdy = 1'b0;
    sv  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg = 1'b0; sv = 1'b0; sd = 1'b0; rdy = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (entry !== '0) begin n_fail++; $display("FAIL reset_entry: got %h want 0", entry); end
    n_checks++; if (idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", idx); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b want 0", ovr); end
    rst = 1'b0;
    exp_ovr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    logic [EW-1:0] words [NE];
    words[0] = 22'h2AAAAA; words[1] = 22'h155555; words[2] = 22'h3FFFFF;
    start_load();
    for (int k = 0; k < NE; k++) begin
      send_word(words[k], 1'b0, 1'b1);
      n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL nom_valid%0d: got %b want 1", k, valid); end
      n_checks++; if (entry !== words[k]) begin n_fail++; $display("FAIL nom_entry%0d: got %h want %h", k, entry, words[k]); end
      n_checks++; if (idx !== 2'(exp_idx)) begin n_fail++; $display("FAIL nom_idx%0d: got %0d want %0d", k, idx, exp_idx); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL nom_early_done%0d: got %b want 0", k, done); end
      @(negedge clk);
      exp_idx++;
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL nom_drop%0d: got %b want 0", k, valid); end
      n_checks++; if (done !== (exp_idx == NE)) begin n_fail++; $display("FAIL nom_done%0d: got %b want %b", k, done, exp_idx == NE); end
    end
    // DONE ignores serial input and holds until enable drops.
    for (int c = 0; c < 4; c++) begin
      sv = 1'b1; sd = 1'($urandom);
      @(negedge clk);
      n_checks++; if (done !== 1'b1 || valid !== 1'b0) begin n_fail++; $display("FAIL done_hold%0d: got done=%b valid=%b want 1/0", c, done, valid); end
    end
    sv = 1'b0;
    n_checks++; if (ovr !== exp_ovr) begin n_fail++; $display("FAIL done_no_ovr: got %b want %b", ovr, exp_ovr); end
    end_load();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_clear: got %b want 0", done); end
  endtask

  task automatic test_backpressure();
    logic [EW-1:0] w;
    w = 22'h0ABCDE;
    start_load();
    send_word(w, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      n_checks++; if (valid !== 1'b1 || entry !== w || idx !== 2'd0) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%b e=%h i=%0d want 1/%h/0", c, valid, entry, idx, w);
      end
      @(negedge clk);
    end
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    exp_idx++;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL bp_accept: got %b want 0", valid); end
    w = 22'($urandom);
    send_word(w, 1'b0, 1'b0);
    n_checks++; if (entry !== w || idx !== 2'(exp_idx)) begin
      n_fail++; $display("FAIL bp_next: got e=%h i=%0d want %h/%0d", entry, idx, w, exp_idx);
    end
    end_load();
  endtask

  task automatic test_overrun();
    logic [EW-1:0] w1, w2;
    w1 = 22'($urandom); w2 = 22'($urandom);
    start_load();
    send_word(w1, 1'b0, 1'b0);
    n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_pre: got %b want 0", ovr); end
    for (int c = 0; c < 2; c++) begin
      sv = 1'b1; sd = 1'($urandom);
      @(negedge clk);
    end
    sv = 1'b0;
    exp_ovr = 1'b1;
    n_checks++; if (ovr !== exp_ovr) begin n_fail++; $display("FAIL ovr_set: got %b want 1", ovr); end
    n_checks++; if (valid !== 1'b1 || entry !== w1) begin n_fail++; $display("FAIL ovr_entry: got v=%b e=%h want 1/%h", valid, entry, w1); end
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    exp_idx++;
    send_word(w2, 1'b0, 1'b0);
    n_checks++; if (entry !== w2 || idx !== 2'(exp_idx)) begin
      n_fail++; $display("FAIL ovr_next: got e=%h i=%0d want %h/%0d", entry, idx, w2, exp_idx);
    end
    end_load();
    n_checks++; if (ovr !== exp_ovr) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", ovr); end
  endtask

  task automatic test_gapped();
    logic [EW-1:0] w;
    w = 22'($urandom);
    start_load();
    send_word(w, 1'b1, 1'b0);
    n_checks++; if (valid !== 1'b1 || entry !== w) begin n_fail++; $display("FAIL gap_word: got v=%b e=%h want 1/%h", valid, entry, w); end
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    exp_idx++;
    send_word(w, 1'b0, 1'b0);
    n_checks++; if (entry !== w || idx !== 2'(exp_idx)) begin n_fail++; $display("FAIL gap_ref: got e=%h i=%0d want %h/%0d", entry, idx, w, exp_idx); end
    end_load();
  endtask

  task automatic test_abort();
    logic [EW-1:0] w0, w1, w2;
    w0 = 22'($urandom); w1 = 22'($urandom); w2 = 22'($urandom);
    start_load();
    send_word(w0, 1'b0, 1'b1);
    @(negedge clk);
    rdy = 1'b0;
    for (int i = EW - 1; i > EW - 11; i--) begin
      @(negedge clk);
      sv = 1'b1; sd = w1[i];
    end
    @(negedge clk);
    sv = 1'b0; cfg = 1'b0;
    @(negedge clk);
    exp_idx = 0;
    n_checks++; if (valid !== 1'b0 || idx !== 2'd0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_state: got v=%b i=%0d d=%b want 0/0/0", valid, idx, done);
    end
    start_load();
    send_word(w2, 1'b0, 1'b0);
    n_checks++; if (valid !== 1'b1 || entry !== w2 || idx !== 2'd0) begin
      n_fail++; $display("FAIL abort_reload: got v=%b e=%h i=%0d want 1/%h/0", valid, entry, idx, w2);
    end
    end_load();
  endtask

  task automatic test_random();
    logic [EW-1:0] w;
    int stall;
    for (int ld = 0; ld < 4; ld++) begin
      start_load();
      for (int k = 0; k < NE; k++) begin
        w = 22'($urandom);
        send_word(w, 1'($urandom), 1'b0);
        stall = int'($urandom_range(0, 3));
        for (int c = 0; c <= stall; c++) begin
          n_checks++; if (valid !== 1'b1 || entry !== w || idx !== 2'(exp_idx)) begin
            n_fail++; $display("FAIL rnd_pres%0d_%0d: got v=%b e=%h i=%0d want 1/%h/%0d", ld, k, valid, entry, idx, w, exp_idx);
          end
          if (c < stall) @(negedge clk);
        end
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        exp_idx++;
        n_checks++; if (valid !== 1'b0 || done !== (exp_idx == NE)) begin
          n_fail++; $display("FAIL rnd_acc%0d_%0d: got v=%b d=%b want 0/%b", ld, k, valid, done, exp_idx == NE);
        end
      end
      end_load();
    end
  endtask

  task automatic test_reset_mid();
    logic [EW-1:0] w0, w1;
    w0 = 22'($urandom); w1 = 22'($urandom);
    start_load();
    send_word(w0, 1'b0, 1'b1);
    @(negedge clk);
    rdy = 1'b0;
    exp_idx++;
    send_word(w1, 1'b0, 1'b0);
    sv = 1'b1; sd = 1'b1;
    @(negedge clk);
    sv = 1'b0;
    n_checks++; if (valid !== 1'b1 || ovr !== 1'b1 || idx !== 2'(exp_idx)) begin
      n_fail++; $display("FAIL rmid_pre: got v=%b o=%b i=%0d want 1/1/%0d", valid, ovr, idx, exp_idx);
    end
    rst = 1'b1; rdy = 1'b1;
    @(negedge clk);
    exp_idx = 0; exp_ovr = 1'b0;
    n_checks++; if (entry !== '0 || idx !== 2'd0 || valid !== 1'b0 || done !== 1'b0 || ovr !== exp_ovr) begin
      n_fail++; $display("FAIL rmid_outs: got e=%h i=%0d v=%b d=%b o=%b want all 0", entry, idx, valid, done, ovr);
    end
    rst = 1'b0; rdy = 1'b0;
    end_load();
  endtask

  initial begin
    exp_idx = 0;
    exp_ovr = 1'b0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_gapped();
    test_abort();
    test_random();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
